// File: rtl/n_clic_pq.sv
// n_clic_pq: CLIC-style prioritized interrupt controller with CSR access and a nested-threshold stack.
// Latency: CSR read is combinational; CSR writes, pending and threshold update on the next edge; int_req trails state by one cycle.
// Backpressure: none; the core acks with int_take, and int_req is held low while the nesting stack is full.
//
// Ports: clk/reset (async active-low); csr_enable/csr_addr/csr_op/rs1_zimm/rs1_data -> out (old CSR value);
//        ext_irq lines; int_take/int_ret from the core; int_req/int_id/int_prio registered request; stack_full.
// csr_op encoding (funct3): 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 perform no write.
// Optional feature macro: CLIC_LEVEL_TRIG_EN adds a per-vector trigger-mode bit (1 = level-sensitive).
module n_clic_pq #(
    parameter int N_VEC       = 8,
    parameter int PRIO_BITS   = 3,
    parameter int STACK_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     csr_enable,
    input  logic [11:0]              csr_addr,
    input  logic [4:0]               rs1_zimm,
    input  logic [31:0]              rs1_data,
    input  logic [2:0]               csr_op,
    input  logic [N_VEC-1:0]         ext_irq,
    input  logic                     int_take,
    input  logic                     int_ret,
    output logic [31:0]              out,
    output logic                     int_req,
    output logic [$clog2(N_VEC)-1:0] int_id,
    output logic [PRIO_BITS-1:0]     int_prio,
    output logic                     stack_full
);
    localparam int IDW = $clog2(N_VEC);
    localparam int DW  = $clog2(STACK_DEPTH + 1);
`ifdef CLIC_LEVEL_TRIG_EN
    localparam int VW  = PRIO_BITS + 3;
`else
    localparam int VW  = PRIO_BITS + 2;
`endif

    logic [N_VEC-1:0]     pend_q, pend_d, en_q, en_d;
    logic [PRIO_BITS-1:0] prio_q  [N_VEC];
    logic [PRIO_BITS-1:0] prio_d  [N_VEC];
`ifdef CLIC_LEVEL_TRIG_EN
    logic [N_VEC-1:0]     trig_q, trig_d;
`endif
    logic [N_VEC-1:0]     irq_prev_q;
    logic [PRIO_BITS-1:0] thresh_q, thresh_d;
    logic [DW-1:0]        depth_q, depth_d;
    logic [PRIO_BITS-1:0] stack_q [STACK_DEPTH];
    logic [PRIO_BITS-1:0] stack_d [STACK_DEPTH];
    logic                 int_req_q, int_req_d;
    logic [IDW-1:0]       int_id_q, int_id_d;
    logic [PRIO_BITS-1:0] int_prio_q, int_prio_d;

    logic [31:0]          rdata, operand;
    logic [VW-1:0]        csr_new;
    logic                 csr_wr, take, ret;
    logic [N_VEC-1:0]     edges;
    logic [PRIO_BITS-1:0] pop_val, best_prio;
    logic [IDW-1:0]       best_id;
    logic                 found;

    // Current value of the addressed CSR; also the base for set/clear ops.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_VEC; i++) begin
            if (csr_addr == 12'hB00 + 12'(i)) begin
`ifdef CLIC_LEVEL_TRIG_EN
                rdata = 32'({trig_q[i], prio_q[i], en_q[i], pend_q[i]});
`else
                rdata = 32'({prio_q[i], en_q[i], pend_q[i]});
`endif
            end
        end
        if (csr_addr == 12'h347) rdata = 32'(thresh_q);
        if (csr_addr == 12'h350) rdata = 32'(depth_q);
    end

    assign out     = csr_enable ? rdata : 32'd0;
    assign operand = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;

    always_comb begin
        case (csr_op[1:0])
            2'b01:   csr_new = operand[VW-1:0];
            2'b10:   csr_new = rdata[VW-1:0] | operand[VW-1:0];
            2'b11:   csr_new = rdata[VW-1:0] & ~operand[VW-1:0];
            default: csr_new = rdata[VW-1:0];
        endcase
    end

    // Set/clear with a zero operand is a pure read and must not write.
    assign csr_wr = csr_enable && (csr_op[1:0] != 2'b00) &&
                    ((csr_op[1:0] == 2'b01) || (operand != 32'd0));
    assign take   = int_take && int_req_q;
    assign ret    = int_int_ret_ok();
    assign edges  = ext_irq & ~irq_prev_q;
    assign stack_full = (depth_q == DW'(STACK_DEPTH));

    // A valid take in the same cycle wins over a return.
    function automatic logic int_int_ret_ok();
        return int_ret && !(int_take && int_req_q) && (depth_q != '0);
    endfunction

    always_comb begin
        pend_d   = pend_q;
        en_d     = en_q;
        prio_d   = prio_q;
`ifdef CLIC_LEVEL_TRIG_EN
        trig_d   = trig_q;
`endif
        thresh_d = thresh_q;
        depth_d  = depth_q;
        stack_d  = stack_q;
        pop_val  = '0;
        // Pending precedence: edge set over take clear over CSR write (applied in reverse order).
        for (int i = 0; i < N_VEC; i++) begin
            if (csr_wr && (csr_addr == 12'hB00 + 12'(i))) begin
                pend_d[i] = csr_new[0];
                en_d[i]   = csr_new[1];
                prio_d[i] = csr_new[2 +: PRIO_BITS];
`ifdef CLIC_LEVEL_TRIG_EN
                trig_d[i] = csr_new[VW-1];
`endif
            end
            if (take && (int_id_q == IDW'(i))) pend_d[i] = 1'b0;
            if (edges[i]) pend_d[i] = 1'b1;
`ifdef CLIC_LEVEL_TRIG_EN
            if (trig_q[i]) pend_d[i] = ext_irq[i];
`endif
        end
        for (int k = 0; k < STACK_DEPTH; k++) begin
            if (DW'(k) == depth_q - DW'(1)) pop_val = stack_q[k];
        end
        if (take) begin
            for (int k = 0; k < STACK_DEPTH; k++) begin
                if (DW'(k) == depth_q) stack_d[k] = thresh_q;
            end
            thresh_d = int_prio_q;
            depth_d  = depth_q + DW'(1);
        end else if (ret) begin
            thresh_d = pop_val;
            depth_d  = depth_q - DW'(1);
        end else if (csr_wr && (csr_addr == 12'h347)) begin
            thresh_d = csr_new[PRIO_BITS-1:0];
        end
    end

    // Highest priority wins; scanning downward with >= lets the lowest index win ties.
    always_comb begin
        found     = 1'b0;
        best_id   = '0;
        best_prio = '0;
        for (int i = N_VEC - 1; i >= 0; i--) begin
            if (pend_q[i] && en_q[i] && (prio_q[i] > thresh_q) &&
                (!found || (prio_q[i] >= best_prio))) begin
                found     = 1'b1;
                best_id   = IDW'(i);
                best_prio = prio_q[i];
            end
        end
        // Drop the request in the take cycle so a stale winner is never presented twice.
        int_req_d  = found && !stack_full && !take;
        int_id_d   = int_req_d ? best_id   : int_id_q;
        int_prio_d = int_req_d ? best_prio : int_prio_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q     <= '0;
            en_q       <= '0;
            for (int i = 0; i < N_VEC; i++) prio_q[i] <= '0;
`ifdef CLIC_LEVEL_TRIG_EN
            trig_q     <= '0;
`endif
            irq_prev_q <= '0;
            thresh_q   <= '0;
            depth_q    <= '0;
            for (int k = 0; k < STACK_DEPTH; k++) stack_q[k] <= '0;
            int_req_q  <= 1'b0;
            int_id_q   <= '0;
            int_prio_q <= '0;
        end else begin
            pend_q     <= pend_d;
            en_q       <= en_d;
            prio_q     <= prio_d;
`ifdef CLIC_LEVEL_TRIG_EN
            trig_q     <= trig_d;
`endif
            irq_prev_q <= ext_irq;
            thresh_q   <= thresh_d;
            depth_q    <= depth_d;
            stack_q    <= stack_d;
            int_req_q  <= int_req_d;
            int_id_q   <= int_id_d;
            int_prio_q <= int_prio_d;
        end
    end

    assign int_req  = int_req_q;
    assign int_id   = int_id_q;
    assign int_prio = int_prio_q;
endmodule

// File: tb/tb_n_clic_pq.sv
// tb_n_clic_pq: scoreboard-driven bench for n_clic_pq (default parameters).
// Latency: checks CSR reads combinationally and int_req one cycle after state changes.
// Backpressure: exercises stack_full masking of int_req.
module tb_n_clic_pq;
    localparam logic [2:0] OP_RW = 3'b001, OP_RS = 3'b010, OP_RC = 3'b011;
    localparam logic [2:0] OP_RSI = 3'b110, OP_RCI = 3'b111;

    logic        clk = 1'b0, reset = 1'b0, csr_enable = 1'b0, int_take = 1'b0, int_ret = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [4:0]  rs1_zimm = '0;
    logic [31:0] rs1_data = '0;
    logic [2:0]  csr_op = '0;
    logic [7:0]  ext_irq = '0;
    logic [31:0] out;
    logic        int_req, stack_full;
    logic [2:0]  int_id, int_prio;

    int checks = 0, errors = 0;
    logic [31:0] rd_q[$];
    logic [6:0]  irq_q[$];
    logic [31:0] got, exp32;
    logic [6:0]  exp7;

    n_clic_pq dut (
        .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
        .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .csr_op(csr_op), .ext_irq(ext_irq),
        .int_take(int_take), .int_ret(int_ret), .out(out), .int_req(int_req),
        .int_id(int_id), .int_prio(int_prio), .stack_full(stack_full)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic csr_wr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] v);
        csr_enable = 1'b1; csr_op = op; csr_addr = a; rs1_data = v; rs1_zimm = v[4:0];
        tick(1);
        csr_enable = 1'b0; csr_op = '0; rs1_data = '0; rs1_zimm = '0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        csr_enable = 1'b1; csr_op = OP_RS; rs1_data = '0; rs1_zimm = '0; csr_addr = a;
        #1 v = out;
        csr_enable = 1'b0; csr_op = '0;
    endtask

    task automatic pulse(input int i);
        ext_irq[i] = 1'b1; tick(1); ext_irq[i] = 1'b0;
    endtask

    task automatic take_one();
        int_take = 1'b1; tick(1); int_take = 1'b0;
    endtask

    task automatic ret_one();
        int_ret = 1'b1; tick(1); int_ret = 1'b0;
    endtask

    task automatic test_reset();
        tick(3);
        irq_q.push_back(7'd0);
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL reset_req: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
        checks++;
        if (stack_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", stack_full); end
        rd_q.push_back(32'd0); rd(12'h347, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL reset_thresh: got %h exp %h", got, exp32); end
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_csr_rw();
        csr_wr(OP_RW, 12'hB03, 32'h16);
        rd_q.push_back(32'h16); rd(12'hB03, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL rw_b03: got %h exp %h", got, exp32); end
        csr_wr(OP_RSI, 12'hB03, 32'h0);
        rd_q.push_back(32'h16); rd(12'hB03, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL rsi_zero: got %h exp %h", got, exp32); end
        csr_wr(OP_RCI, 12'hB03, 32'h2);
        rd_q.push_back(32'h14); rd(12'hB03, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL rci_en: got %h exp %h", got, exp32); end
        csr_wr(OP_RSI, 12'hB03, 32'h2);
        rd_q.push_back(32'h16); rd(12'hB03, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL rsi_en: got %h exp %h", got, exp32); end
        csr_wr(OP_RW, 12'h347, 32'hFFFF_FFFF);
        rd_q.push_back(32'h7); rd(12'h347, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL thresh_mask: got %h exp %h", got, exp32); end
        csr_wr(OP_RW, 12'h347, 32'h0);
        csr_wr(OP_RW, 12'h350, 32'h5);
        rd_q.push_back(32'h0); rd(12'h350, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL depth_ro: got %h exp %h", got, exp32); end
        csr_wr(OP_RW, 12'h123, 32'hFF);
        rd_q.push_back(32'h0); rd(12'h123, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL unmapped: got %h exp %h", got, exp32); end
        csr_wr(OP_RW, 12'hB07, 32'h20);
`ifdef CLIC_LEVEL_TRIG_EN
        rd_q.push_back(32'h20);
`else
        rd_q.push_back(32'h0);
`endif
        rd(12'hB07, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL trig_bit: got %h exp %h", got, exp32); end
        csr_wr(OP_RW, 12'hB07, 32'h0);
    endtask

    task automatic test_edge_irq();
        pulse(3);
        irq_q.push_back(7'd0);
        rd_q.push_back(32'h17); rd(12'hB03, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL edge_pending: got %h exp %h", got, exp32); end
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL edge_req_lag: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
        irq_q.push_back({1'b1, 3'd3, 3'd5});
        tick(1);
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL edge_req: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
        irq_q.push_back({1'b0, 3'd3, 3'd5});
        take_one();
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL take_hold: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
        rd_q.push_back(32'h5); rd(12'h347, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL take_thresh: got %h exp %h", got, exp32); end
        ret_one();
        rd_q.push_back(32'h0); rd(12'h347, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL ret_thresh: got %h exp %h", got, exp32); end
    endtask

    task automatic test_tie_take();
        csr_wr(OP_RW, 12'hB01, 32'h12);
        csr_wr(OP_RW, 12'hB06, 32'h12);
        ext_irq[1] = 1'b1; ext_irq[6] = 1'b1; tick(1); ext_irq = '0;
        irq_q.push_back({1'b1, 3'd1, 3'd4});
        tick(1);
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL tie_req: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
        take_one();
        rd_q.push_back(32'h1); rd(12'h350, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL tie_depth: got %h exp %h", got, exp32); end
        rd_q.push_back(32'h4); rd(12'h347, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL tie_thresh: got %h exp %h", got, exp32); end
        irq_q.push_back({1'b0, 3'd1, 3'd4});
        tick(1);
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL tie_masked: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
        pulse(3);
        irq_q.push_back({1'b1, 3'd3, 3'd5});
        tick(1);
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL preempt_req: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
        take_one();
    endtask

    task automatic test_nesting();
        // Stack so far: [0, 4]; threshold 5.
        csr_wr(OP_RW, 12'hB07, 32'h1A);
        pulse(7);
        tick(1);
        take_one();                          // push 5, threshold 6
        csr_wr(OP_RW, 12'h347, 32'h0);       // vec6 (prio 4) becomes eligible again
        irq_q.push_back({1'b1, 3'd6, 3'd4});
        tick(1);
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL nest_req6: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
        take_one();                          // push 0, threshold 4, depth 4
        checks++;
        if (stack_full !== 1'b1) begin errors++; $display("FAIL full_set: got %b exp 1", stack_full); end
        csr_wr(OP_RW, 12'hB00, 32'h1E);
        pulse(0);
        irq_q.push_back({1'b0, 3'd6, 3'd4});
        tick(2);
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL full_block: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
        ret_one();
        checks++;
        if (stack_full !== 1'b0) begin errors++; $display("FAIL full_clear: got %b exp 0", stack_full); end
        rd_q.push_back(32'h0); rd(12'h347, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL pop0: got %h exp %h", got, exp32); end
        irq_q.push_back({1'b1, 3'd0, 3'd7});
        tick(1);
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL unblock_req: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
        ret_one();
        rd_q.push_back(32'h5); rd(12'h347, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL pop1: got %h exp %h", got, exp32); end
        ret_one();
        rd_q.push_back(32'h4); rd(12'h347, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL pop2: got %h exp %h", got, exp32); end
        ret_one();
        ret_one();                           // depth already 0: ignored
        rd_q.push_back(32'h0); rd(12'h347, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL ret_empty_thresh: got %h exp %h", got, exp32); end
        rd_q.push_back(32'h0); rd(12'h350, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL ret_empty_depth: got %h exp %h", got, exp32); end
    endtask

    task automatic test_edge_vs_clear();
        csr_wr(OP_RW, 12'hB02, 32'h02);
        ext_irq[2] = 1'b1;
        csr_wr(OP_RC, 12'hB02, 32'h1);
        ext_irq[2] = 1'b0;
        rd_q.push_back(32'h03); rd(12'hB02, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL edge_beats_rc: got %h exp %h", got, exp32); end
        csr_wr(OP_RC, 12'hB02, 32'h1);
        rd_q.push_back(32'h02); rd(12'hB02, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL rc_clear: got %h exp %h", got, exp32); end
    endtask

    task automatic test_reset_mid();
        take_one();                          // vec0 taken: depth 1
        rd_q.push_back(32'h1); rd(12'h350, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL mid_depth: got %h exp %h", got, exp32); end
        reset = 1'b0;
        irq_q.push_back(7'd0);
        #1;
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL mid_rst_req: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
        rd_q.push_back(32'h0); rd(12'hB00, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL mid_rst_b00: got %h exp %h", got, exp32); end
        rd_q.push_back(32'h0); rd(12'hB03, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL mid_rst_b03: got %h exp %h", got, exp32); end
        rd_q.push_back(32'h0); rd(12'h350, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL mid_rst_depth: got %h exp %h", got, exp32); end
        tick(2);
        reset = 1'b1;
        irq_q.push_back(7'd0);
        tick(1);
        exp7 = irq_q.pop_front(); checks++;
        if ({int_req, int_id, int_prio} !== exp7) begin errors++; $display("FAIL post_rst_req: got %h exp %h", {int_req, int_id, int_prio}, exp7); end
    endtask

`ifdef CLIC_LEVEL_TRIG_EN
    task automatic test_level();
        csr_wr(OP_RW, 12'hB04, 32'h3E);
        ext_irq[4] = 1'b1;
        tick(2);
        take_one();
        tick(1);
        rd_q.push_back(32'h3F); rd(12'hB04, got); exp32 = rd_q.pop_front(); checks++;
        if (got !== exp32) begin errors++; $display("FAIL level_hold: got %h exp %h", got, exp32); end
        ext_irq[4] = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_csr_rw();
        test_edge_irq();
        test_tie_take();
        test_nesting();
        test_edge_vs_clear();
        test_reset_mid();
`ifdef CLIC_LEVEL_TRIG_EN
        test_level();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
